// File: rtl/regfile_wb_arb.sv
// Write-back arbiter onto register-file port 3 plus a per-register RAW busy scoreboard.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module regfile_wb_arb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  input  logic                 sb_set_valid,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic [AW-1:0]        sb_q_addr1,
  input  logic [AW-1:0]        sb_q_addr2,
  output logic                 sb_busy1,
  output logic                 sb_busy2,
  output logic                 sb_err
);
  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            live;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            xfer;
  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            err_nxt;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AW +: AW];
    assign data_a[i] = req_data[i*DW +: DW];
  end

  // Grants are held off during reset and on the first edge after release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) live <= 1'b0;
    else         live <= 1'b1;
  end

`ifdef WB_ARB_RR_EN
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  // Search starts at the pointer and wraps around
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   ptr <= '0;
    else if (xfer) ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  // Descending scan so the lowest valid index is the last one written
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    gnt          = '0;
    gnt[gnt_idx] = gnt_any;
  end

  assign xfer      = gnt_any & live;
  assign req_ready = gnt & {NREQ{live}};

  // Register-file port 3; r0 writes are accepted but never enabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (xfer) begin
      we3 <= (addr_a[gnt_idx] != '0);
      wa3 <= addr_a[gnt_idx];
      wd3 <= data_a[gnt_idx];
    end else begin
      we3 <= 1'b0;
    end
  end

  // Commit clears, issue sets; a same-cycle set on the committing register wins
  always_comb begin
    busy_nxt = busy;
    err_nxt  = sb_err;
    if (we3) busy_nxt[wa3] = 1'b0;
    if (sb_set_valid && sb_set_addr != '0) begin
      if (busy[sb_set_addr] && !(we3 && wa3 == sb_set_addr)) err_nxt = 1'b1;
      busy_nxt[sb_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      sb_err <= err_nxt;
    end
  end

  assign sb_busy1 = busy[sb_q_addr1] & (sb_q_addr1 != '0);
  assign sb_busy2 = busy[sb_q_addr2] & (sb_q_addr2 != '0);

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed vectors, per-cycle reference model compare, literal spot checks.
module tb_regfile_wb_arb;
  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 1 << AW;

  logic                 clk;
  logic                 resetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 we3;
  logic [AW-1:0]        wa3;
  logic [DW-1:0]        wd3;
  logic                 sb_set_valid;
  logic [AW-1:0]        sb_set_addr;
  logic [AW-1:0]        sb_q_addr1;
  logic [AW-1:0]        sb_q_addr2;
  logic                 sb_busy1;
  logic                 sb_busy2;
  logic                 sb_err;

  int total = 0;
  int bad   = 0;

  regfile_wb_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr),
    .sb_q_addr1(sb_q_addr1), .sb_q_addr2(sb_q_addr2),
    .sb_busy1(sb_busy1), .sb_busy2(sb_busy2), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register-file view of what must have happened
  bit          m_busy [NREG];
  bit          m_err  = 1'b0;
  bit          m_live = 1'b0;
  int          m_last = NREQ - 1;
  logic        m_we   = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;

  function automatic int pick();
    if (!resetn || !m_live) return -1;
`ifdef WB_ARB_RR_EN
    for (int k = 1; k <= int'(NREQ); k++) begin
      int i;
      i = (m_last + k) % int'(NREQ);
      if (req_valid[i]) return i;
    end
`else
    for (int i = 0; i < int'(NREQ); i++) if (req_valid[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = pick();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    int g;
    bit was_busy;
    if (!resetn) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_err = 1'b0; m_live = 1'b0; m_last = NREQ - 1;
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      g = pick();
      if (sb_set_valid && sb_set_addr != 0) begin
        was_busy = m_busy[sb_set_addr];
        if (m_we) m_busy[m_wa] = 1'b0;
        if (was_busy && !(m_we && m_wa == sb_set_addr)) m_err = 1'b1;
        m_busy[sb_set_addr] = 1'b1;
      end else if (m_we) begin
        m_busy[m_wa] = 1'b0;
      end
      if (g >= 0) begin
        m_wa = req_addr[g*AW +: AW];
        m_wd = req_data[g*DW +: DW];
        m_we = (m_wa != 0);
        m_last = g;
      end else begin
        m_we = 1'b0;
      end
      m_live = 1'b1;
    end
  endtask

  // Per-cycle compare just after each rising edge
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    chk("m_ready", req_ready, exp_ready());
    chk("m_we3", we3, m_we);
    chk("m_wa3", wa3, m_wa);
    chk("m_wd3", wd3, m_wd);
    chk("m_busy1", sb_busy1, (sb_q_addr1 != 0) && m_busy[sb_q_addr1]);
    chk("m_busy2", sb_busy2, (sb_q_addr2 != 0) && m_busy[sb_q_addr2]);
    chk("m_err", sb_err, m_err);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  logic [NREQ-1:0] exp_seq [6];

  initial begin
`ifdef WB_ARB_RR_EN
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;
`else
    foreach (exp_seq[i]) exp_seq[i] = 3'b001;
`endif
    // Reset with everything active
    resetn = 1'b0;
    req_valid = '1; req_addr = '0; req_data = '0;
    set_req(0, 1, 4, 32'hA0); set_req(1, 1, 5, 32'hA1); set_req(2, 1, 6, 32'hA2);
    sb_set_valid = 1'b1; sb_set_addr = 9; sb_q_addr1 = 9; sb_q_addr2 = 5;
    repeat (4) begin
      tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_we3", we3, 0);
      chk("rst_err", sb_err, 0);
    end

    // Release: no grant on the first sampled edge, grant the cycle after
    tick();
    req_valid = '0; sb_set_valid = 1'b0; sb_q_addr1 = 0; sb_q_addr2 = 0;
    set_req(1, 1, 7, 32'hDEADBEEF);
    resetn = 1'b1;
    #1 chk("rel_hold", req_ready, 0);
    tick(); chk("first_grant", req_ready, 3'b010);
    tick();
    chk("first_we3", we3, 1); chk("first_wa3", wa3, 7); chk("first_wd3", wd3, 32'hDEADBEEF);
    set_req(1, 0, 0, 0);

    // Fresh reset, then all three requesters valid for six grants
    tick(); resetn = 1'b0;
    tick(); tick(); resetn = 1'b1;
    tick();
    set_req(0, 1, 1, 32'h11); set_req(1, 1, 2, 32'h22); set_req(2, 1, 3, 32'h33);
    for (int i = 0; i < 6; i++) begin
      #1 chk("seq", req_ready, exp_seq[i]);
      tick();
    end
    req_valid = '0;

    // r0 write is granted but never enabled, and r0 is never busy
    tick();
    set_req(0, 1, 0, 32'h1234); sb_set_valid = 1'b1; sb_set_addr = 0; sb_q_addr1 = 0;
    #1 chk("r0_ready", req_ready, 3'b001);
    tick(); req_valid = '0; sb_set_valid = 1'b0;
    chk("r0_we3", we3, 0);
    tick(); chk("r0_busy", sb_busy1, 0);

    // Scoreboard set and commit-clear of r5
    sb_set_valid = 1'b1; sb_set_addr = 5; sb_q_addr1 = 5;
    tick(); sb_set_valid = 1'b0;
    chk("sb_set", sb_busy1, 1);
    set_req(0, 1, 5, 32'h55);
    tick(); req_valid = '0;
    chk("sb_wb_we3", we3, 1); chk("sb_busy_n", sb_busy1, 1);
    tick(); chk("sb_clr", sb_busy1, 0);

    // Re-set r5 in the same cycle its write commits
    sb_set_valid = 1'b1; sb_set_addr = 5;
    tick(); sb_set_valid = 1'b0;
    chk("sb_reset_busy", sb_busy1, 1);
    set_req(0, 1, 5, 32'h56);
    tick(); req_valid = '0;
    chk("sb_same_we3", we3, 1);
    sb_set_valid = 1'b1; sb_set_addr = 5;
    tick(); sb_set_valid = 1'b0;
    chk("sb_same_busy", sb_busy1, 1); chk("sb_same_err", sb_err, 0);

    // Back-to-back writes to r3
    set_req(0, 1, 3, 32'h1);
    tick();
    chk("b2b_we3_a", we3, 1); chk("b2b_wa3_a", wa3, 3); chk("b2b_wd3_a", wd3, 32'h1);
    set_req(0, 1, 3, 32'h2);
    tick(); req_valid = '0;
    chk("b2b_we3_b", we3, 1); chk("b2b_wd3_b", wd3, 32'h2);
    tick(); chk("b2b_we3_c", we3, 0);

    // Double set of r9 is a sticky error until reset
    sb_q_addr2 = 9; sb_set_valid = 1'b1; sb_set_addr = 9;
    tick(); tick(); sb_set_valid = 1'b0;
    chk("r9_err", sb_err, 1);
    repeat (3) tick();
    chk("r9_sticky", sb_err, 1); chk("r9_busy", sb_busy2, 1);
    resetn = 1'b0;
    #1 chk("r9_rst_err", sb_err, 0); chk("r9_rst_busy", sb_busy2, 0);
    tick(); tick(); resetn = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter and scoreboard for the single-write-port register file. It collects write-back requests from up to `NREQ` producers (ALU, load unit, multi-cycle mul/div) and grants one per cycle. The granted request is registered onto the register file's third port (`we3`/`wa3`/`wd3`). It also keeps a per-register busy scoreboard that issue logic sets and committed writes clear, so decode can stall on RAW hazards.

## Interface
Parameters:
- `NREQ`, 3: number of write-back requesters (2..4).
- `DW`, 32: data width.
- `AW`, 5: register address width; scoreboard has 2^AW bits.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester write-back request.
- `req_ready`  out  NREQ  per-requester grant; a transfer occurs when valid and ready are both high at a rising edge.
- `req_addr`  in  NREQ*AW  destination register per requester, index i at bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  write data per requester, index i at bits [i*DW +: DW].
- `we3`  out  1  register-file write enable (registered).
- `wa3`  out  AW  register-file write address (registered).
- `wd3`  out  DW  register-file write data (registered).
- `sb_set_valid`  in  1  issue marks a destination register pending.
- `sb_set_addr`  in  AW  register to mark pending.
- `sb_q_addr1`, `sb_q_addr2`  in  AW each  source registers queried by decode.
- `sb_busy1`, `sb_busy2`  out  1 each  combinational busy status of the queried registers.
- `sb_err`  out  1  sticky error flag: set attempted on an already-busy register.

## Operation
- Grant logic is combinational from `req_valid` and the priority state. At most one `req_ready` bit is high per cycle. `req_ready[i]` is never high unless `req_valid[i]` is high.
- The output register is always free because the register file accepts a write every cycle. Any cycle with at least one valid request produces exactly one grant.
- On a transfer from requester g:
  - `wa3 <= req_addr[g]` and `wd3 <= req_data[g]`.
  - `we3 <= 1` if `req_addr[g] != 0`; otherwise `we3 <= 0`. Writes to r0 are accepted and discarded.
- With no transfer, `we3 <= 0`; `wa3`/`wd3` hold their previous values.
- Scoreboard (`busy[2^AW-1:0]`):
  - Set: `sb_set_valid && sb_set_addr != 0` sets `busy[sb_set_addr]`.
  - Clear: when `we3` is high at a rising edge (the cycle the register file commits), `busy[wa3]` is cleared.
  - Same register set and cleared in the same cycle: set wins and the bit stays 1, because a new producer has issued.
  - Set on a register already busy with no same-cycle clear: the bit stays 1 and `sb_err <= 1`. `sb_err` clears only on reset.
  - `sb_busy1/2 = busy[sb_q_addr1/2]`, forced to 0 for address 0. There is no bypass of same-cycle sets or clears; the output reflects registered state.
- Requesters must hold `req_valid`, `req_addr` and `req_data` stable until granted. Dropping `req_valid` before a grant is permitted; nothing is recorded.

## Timing
- Reset (asynchronous assert, `resetn` low):
  - `we3=0`, `wa3=0`, `wd3=0`.
  - `busy=0`, so `sb_busy1/2=0`.
  - `sb_err=0`.
  - Round-robin pointer=0.
  - `req_ready` is forced to 0 while reset is asserted.
- Latency:
  - Grant to `we3` high: 1 cycle. The transfer is at edge N, `we3`/`wa3`/`wd3` are valid during cycle N..N+1, and the register file writes at edge N+1.
  - Busy clears at edge N+1, so `sb_busy` is low from cycle N+1 onward.
- Throughput: one write per cycle sustained.
- Reset mid-operation: pending outputs and scoreboard are discarded. Requesters re-present after reset deasserts; no grant occurs in the first cycle that `resetn` is sampled high.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin arbitration.
  - After a grant to requester g, priority order starts at (g+1) mod NREQ.
  - The pointer advances only on a grant.
  - No requester waits more than NREQ-1 grants.
- Not defined: fixed priority; the lowest index wins (requester 0 highest). The pointer register is not instantiated.

## Test plan
- Reset with all inputs active:
  - Required: `req_ready=0`, `we3=0` and `sb_err=0` throughout.
  - After release, a single `req_valid[1]` with addr 7, data 0xDEADBEEF is granted the first cycle after release.
  - Then `we3=1`, `wa3=7`, `wd3=0xDEADBEEF` one cycle later.
- All three requesters valid continuously for 6 cycles:
  - With RR: grant sequence 0,1,2,0,1,2.
  - Without RR: 0,0,0,0,0,0.
- Request to r0 with data 0x1234: `req_ready` pulses and `we3` stays 0; a subsequent `sb_busy` query of r0 returns 0.
- Scoreboard:
  - Set r5 → `sb_busy1` (q=5) high the next cycle.
  - Write-back to r5 granted at edge N → `sb_busy1` low from cycle N+1.
  - Set r5 in the same cycle `we3` commits r5 → busy stays 1 and `sb_err` stays 0.
- Set r9 twice without an intervening write → `sb_err` goes high and remains high until `resetn` is asserted.
- Back-to-back grants to r3 with 0x1 then 0x2 → `we3` high two consecutive cycles, with `wd3` 0x1 then 0x2.
